// File: rtl/minne_ctrl.sv
// rtl/minne_ctrl.sv - settle/strobe access sequencer for the 8-word memory array
// Single or burst reads/writes; address wraps 7->0; read data registered for the consumer.
module minne_ctrl #(
   parameter int DATA_W = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   output logic              o_req_ready,
   input  logic              i_rw,
   input  logic [2:0]        i_start_adr,
   input  logic [2:0]        i_burst_len,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_wready,
   output logic              o_adr2,
   output logic              o_adr1,
   output logic              o_adr0,
   output logic              o_select,
   output logic              o_write_en,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_rw;
   logic [2:0]        r_cnt;
   logic [2:0]        r_adr;
   logic              r_req_ready;
   logic              r_select;
   logic              r_write_en;
   logic              r_wready;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_done;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_rw        <= 1'b0;
         r_cnt       <= 3'd0;
         r_adr       <= 3'd0;
         r_req_ready <= 1'b1;
         r_select    <= 1'b0;
         r_write_en  <= 1'b0;
         r_wready    <= 1'b0;
         r_rdata     <= '0;
         r_rvalid    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         // rvalid and done are single-cycle pulses unless re-armed below
         r_rvalid <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_req) begin
                  r_rw        <= i_rw;
                  r_cnt       <= i_burst_len;
                  r_adr       <= i_start_adr;
                  r_req_ready <= 1'b0;
                  r_state     <= SETUP;
               end
            end
            SETUP: begin
               r_select   <= 1'b1;
               r_write_en <= r_rw;
               r_wready   <= r_rw;
               r_state    <= STROBE;
            end
            STROBE: begin
               r_select   <= 1'b0;
               r_write_en <= 1'b0;
               r_wready   <= 1'b0;
               if (!r_rw) begin
                  r_rdata  <= i_mem_rdata;
                  r_rvalid <= 1'b1;
               end
               if (r_cnt == 3'd0) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt   <= r_cnt - 3'd1;
                  r_adr   <= r_adr + 3'd1;
                  r_state <= SETUP;
               end
            end
            DONE: begin
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready = r_req_ready;
   assign o_select    = r_select;
   assign o_write_en  = r_write_en;
   assign o_wready    = r_wready;
   assign o_adr2      = r_adr[2];
   assign o_adr1      = r_adr[1];
   assign o_adr0      = r_adr[0];
   assign o_mem_wdata = r_write_en ? i_wdata : '0;
   assign o_rdata     = r_rdata;
   assign o_rvalid    = r_rvalid;
   assign o_done      = r_done;

endmodule

// File: tb/tb_minne_ctrl.sv
// tb/tb_minne_ctrl.sv - self-checking bench for minne_ctrl
// Directed and random bursts against a word-level reference memory.
module tb_minne_ctrl;

   localparam int DATA_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic              req_ready;
   logic              rw;
   logic [2:0]        start_adr;
   logic [2:0]        burst_len;
   logic [DATA_W-1:0] wdata;
   logic              wready;
   logic              adr2, adr1, adr0;
   logic              select;
   logic              write_en;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] mem [8];
   logic [DATA_W-1:0] seed [8];
   logic [DATA_W-1:0] ref_mem [8];
   logic              mem_init;
   logic [DATA_W-1:0] exp_rdata;
   logic [2:0]        w_adr;

   always #5 clk = ~clk;

   minne_ctrl #(.DATA_W(DATA_W)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req       (req),
      .o_req_ready (req_ready),
      .i_rw        (rw),
      .i_start_adr (start_adr),
      .i_burst_len (burst_len),
      .i_wdata     (wdata),
      .o_wready    (wready),
      .o_adr2      (adr2),
      .o_adr1      (adr1),
      .o_adr0      (adr0),
      .o_select    (select),
      .o_write_en  (write_en),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .o_rdata     (rdata),
      .o_rvalid    (rvalid),
      .o_done      (done)
   );

   // Behavioural 8-word array behind the decoder
   assign w_adr     = {adr2, adr1, adr0};
   assign mem_rdata = mem[w_adr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 8; i++) mem[i] <= seed[i];
      end else if (select && write_en) begin
         mem[w_adr] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_adr"}, {29'd0, w_adr}, 32'd0);
      check({tag, "_select"}, {31'd0, select}, 32'd0);
      check({tag, "_write_en"}, {31'd0, write_en}, 32'd0);
      check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_wready"}, {31'd0, wready}, 32'd0);
   endtask

   // One complete burst; cycle c counts clock periods after the accepting edge.
   task automatic run_burst(input logic b_rw, input int b_start, input int b_len, input bit hold_req);
      int                n;
      int                k;
      bit                exp_sel;
      bit                exp_rv;
      logic [DATA_W-1:0] wq [8];
      n = b_len + 1;
      for (int i = 0; i < 8; i++) wq[i] = DATA_W'($urandom);
      @(negedge clk);
      req       = 1'b1;
      rw        = b_rw;
      start_adr = 3'(b_start);
      burst_len = 3'(b_len);
      #1;
      check("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      for (int c = 1; c <= 2 * n + 2; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req       = hold_req;
            rw        = ~b_rw;
            start_adr = hold_req ? 3'd3 : 3'($urandom);
            burst_len = 3'($urandom);
         end
         if (c == 2 * n + 1) req = 1'b0;
         exp_sel = (c % 2 == 0) && (c <= 2 * n);
         k = (c - 1) / 2;
         if (k > n - 1) k = n - 1;
         wdata = (exp_sel && b_rw) ? wq[c/2-1] : DATA_W'($urandom);
         exp_rv = !b_rw && (c % 2 == 1) && (c >= 3) && (c <= 2 * n + 1);
         if (exp_rv) exp_rdata = ref_mem[(b_start + (c - 3) / 2) % 8];
         #1;
         check("select", {31'd0, select}, {31'd0, exp_sel});
         check("write_en", {31'd0, write_en}, {31'd0, exp_sel && b_rw});
         check("wready", {31'd0, wready}, {31'd0, exp_sel && b_rw});
         check("mem_wdata", {28'd0, mem_wdata},
               (exp_sel && b_rw) ? {28'd0, wq[c/2-1]} : 32'd0);
         if (c <= 2 * n + 1) check("adr", {29'd0, w_adr}, 32'((b_start + k) % 8));
         check("done", {31'd0, done}, {31'd0, c == 2 * n + 1});
         check("rvalid", {31'd0, rvalid}, {31'd0, exp_rv});
         check("rdata", {28'd0, rdata}, {28'd0, exp_rdata});
         check("req_ready", {31'd0, req_ready}, {31'd0, c == 2 * n + 2});
         if (exp_sel && b_rw) ref_mem[(b_start + k) % 8] = wq[c/2-1];
      end
   endtask

   initial begin
      reset     = 1'b1;
      req       = 1'b0;
      rw        = 1'b0;
      start_adr = 3'd0;
      burst_len = 3'd0;
      wdata     = '0;
      mem_init  = 1'b1;
      exp_rdata = '0;
      for (int i = 0; i < 8; i++) begin
         seed[i]    = DATA_W'($urandom);
         ref_mem[i] = seed[i];
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      check_idle_outputs("reset");
      check("reset_rdata", {28'd0, rdata}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);

      // Single read at 5, known array word
      @(negedge clk);
      mem_init = 1'b1;
      seed[5]    = 4'hA;
      ref_mem[5] = 4'hA;
      @(negedge clk);
      mem_init = 1'b0;
      run_burst(1'b0, 5, 0, 1'b0);
      check("single_read_rdata", {28'd0, rdata}, 32'hA);

      // Write burst wrapping 6,7,0
      run_burst(1'b1, 6, 2, 1'b0);
      // Full 8-word read from 0, with a busy-time request that must be ignored
      run_burst(1'b0, 0, 7, 1'b1);
      run_burst(1'b0, 6, 2, 1'b0);

      // Reset during the strobe of a write burst
      @(negedge clk);
      req       = 1'b1;
      rw        = 1'b1;
      start_adr = 3'd2;
      burst_len = 3'd3;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #1;
      check("pre_reset_select", {31'd0, select}, 32'd1);
      reset = 1'b1;
      exp_rdata = '0;
      #1;
      check_idle_outputs("midburst_reset");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_idle_outputs("post_reset");
         check("post_reset_ready", {31'd0, req_ready}, 32'd1);
      end
      run_burst(1'b0, 7, 1, 1'b0);
      run_burst(1'b0, 2, 3, 1'b0);

      for (int t = 0; t < 25; t++) begin
         run_burst(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom));
      end
      run_burst(1'b0, 0, 7, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
